counter_4_bit_down_prescaled: RTL
=================================

# counter_4_bit_down_prescaled

Loadable 4-bit down counter with a clock-enable prescaler, a one-shot/wrap mode selector and a terminal-count pulse. It counts in the opposite direction to the team's 4-bit up counter. It is the consumer end of the same counting scheme: software or an upstream FSM loads a value, and the block counts it down to zero at a divided rate. Intended for timeouts and delay generation next to the up-counter test infrastructure.

## Interface
- PRESCALE, default 4: enabled clk cycles per count step; legal range 1..256.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- en  in  1  count enable; prescaler advances only while en=1.
- load  in  1  synchronous load strobe; highest priority after reset.
- din  in  4  load value, sampled when load=1.
- mode  in  1  0 = wrap (0 steps to 15), 1 = one-shot (halt at 0).
- out  out  4  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- busy  out  1  high while in RUN state, registered.

## Operation
- State machine with two states:
  - HALT: reset state. Only a load leaves HALT.
  - RUN: counting.
- Prescaler `pre`:
  - Width is max(1, ceil(log2(PRESCALE))) bits.
  - Counts 0..PRESCALE-1 while en=1 and state=RUN.
  - tick = en & RUN & (pre == PRESCALE-1).
  - pre clears to 0 on a tick and on a load.
  - pre holds while en=0.
  - PRESCALE=1 gives a tick on every enabled RUN cycle.
- Priority per edge is reset > load > tick > hold.
- Load, at any state:
  - out <= din, pre <= 0, tc <= 0.
  - If din=0 and mode=1: next state HALT, busy=0.
  - Otherwise: next state RUN, busy=1.
- Tick in RUN (mode sampled at the tick edge):
  - out==1: out <= 0, tc <= 1. If mode=1, go to HALT and busy <= 0. If mode=0, stay in RUN.
  - out==0 (only reachable with mode=0): out <= 15, tc stays 0.
  - Otherwise: out <= out-1, tc <= 0.
- Width rule: 4-bit unsigned arithmetic, no carry or borrow output; the 0->15 step is the only wrap.
- tc is 0 on every edge that does not take the 1->0 step.
- A load at the same edge as a tick suppresses the tick: no decrement, no tc.
- A mode change mid-count takes effect at the next tick.
- en=0 has no effect on load.
- In HALT, out holds its value and tc=0.

## Timing
- Reset values: out=0, tc=0, busy=0, pre=0, state=HALT. They take effect asynchronously on the falling edge of rst and hold while rst=0.
- Load latency is 1 cycle: out=din and busy valid after the load edge.
- With en held high from the load edge, out steps on the PRESCALE-th rising edge after the load edge and every PRESCALE edges after that.
- Loading N≥1 in one-shot mode with en=1 gives out=0, tc=1 and busy=0 exactly N·PRESCALE edges after the load edge.
- tc is high for exactly one clk cycle, concurrent with out becoming 0.
- Deasserting en stretches the step by the number of cycles en was low; no partial-step loss.
- Reset mid-RUN aborts the count; after rst=1 the block sits in HALT until a load.

## Test plan
- Async reset: in RUN with out=9, drive rst=0 between clock edges -> out=0, tc=0, busy=0 before the next rising edge; no counting after rst=1 without a load.
- One-shot, PRESCALE=4: load din=3, mode=1, en=1 -> out=3 after the load edge, 2 at +4, 1 at +8, 0 at +12 with tc=1 for one cycle and busy falling to 0 at the same edge; out stays 0 for 20 more cycles.
- Wrap mode: load din=2, mode=0 -> out sequence 2,1,0,15,14 at 4-cycle spacing; tc=1 only on the 1->0 step; busy stays 1.
- Enable gating: load 5, en=1 for 2 cycles, en=0 for 10 cycles, en=1 -> first step to 4 occurs 14 edges after the load; out and pre do not change while en=0.
- Load/tick collision: load din=7 on the same edge a tick would take out from 1 to 0 -> out=7, tc=0, busy=1, next step after 4 enabled cycles.
- Zero load: din=0, mode=1 -> busy=0, tc=0, out=0 and held. Then din=0, mode=0 -> busy=1 and out=15 after 4 enabled cycles, tc=0.

Source files
------------

// File: rtl/counter_4_bit_down_prescaled_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_4_bit_down_prescaled_if : control/status bundle of the down counter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface counter_4_bit_down_prescaled_if;
  logic       en;
  logic       load;
  logic [3:0] din;
  logic       mode;
  logic [3:0] out;
  logic       tc;
  logic       busy;

  modport master (
    output en, load, din, mode,
    input  out, tc, busy
  );

  modport slave (
    input  en, load, din, mode,
    output out, tc, busy
  );
endinterface
`default_nettype wire

// File: rtl/counter_4_bit_down_prescaled.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_4_bit_down_prescaled : loadable 4-bit down counter, prescaled steps
// Revision: 1.0
// ---------------------------------------------------------------------------
module counter_4_bit_down_prescaled #(
  parameter int PRESCALE = 4
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  counter_4_bit_down_prescaled_if.slave  bus
);

  localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [0:0] {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    out_q, out_d;
  logic          tc_q, tc_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    out_d   = out_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      out_d   = bus.din;
      pre_d   = '0;
      state_d = (bus.din == 4'd0 && bus.mode) ? ST_HALT : ST_RUN;
    end else if (state_q == ST_RUN && bus.en) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        if (out_q == 4'd1) begin
          out_d = 4'd0;
          tc_d  = 1'b1;
          if (bus.mode) state_d = ST_HALT;
        end else if (out_q == 4'd0) begin
          out_d = 4'd15;
        end else begin
          out_d = out_q - 4'd1;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HALT;
      pre_q   <= '0;
      out_q   <= 4'd0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      out_q   <= out_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;

endmodule
`default_nettype wire
